// File: rtl/pio_host_bridge_if.sv
// rtl/pio_host_bridge_if.sv - host byte-link streams for the PIO host bridge
interface pio_host_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Host side: sends command bytes, consumes reply bytes
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    // Bridge side: consumes command bytes, sends reply bytes
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/pio_host_bridge.sv
// rtl/pio_host_bridge.sv - frames host command bytes into PIO actions and returns pull data
module pio_host_bridge #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    pio_host_bridge_if.slave host,
    output logic [3:0]       pio_action,
    output logic [1:0]       pio_mindex,
    output logic [4:0]       pio_index,
    output logic [31:0]      pio_din,
    input  logic [31:0]      pio_dout,
    output logic             busy,
    output logic             frame_err
);
    // Idle counter only needs to reach TIMEOUT-1; the timeout fires on that cycle.
    localparam int unsigned   IW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT == 0) ? '0 : IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        REPLY = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;

    logic [3:0]    act_q;
    logic [1:0]    mindex_q;
    logic [4:0]    index_q;
    logic [23:0]   din_lo_q;
    logic [31:0]   reply_q;

    logic          rx_open;
    logic          rx_fire;
    logic          tx_fire;
    logic          timeout_hit;
    logic          in_frame;
    logic [7:0]    tx_byte;

    assign rx_open     = (state_q == IDLE) || (state_q == HDR) || (state_q == DATA);
    assign rx_fire     = rx_open && host.rx_valid;
    assign tx_fire     = (state_q == REPLY) && host.tx_ready;
    assign in_frame    = (state_q == HDR) || (state_q == DATA);
    assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_LAST) && !rx_fire;

    assign host.rx_ready = rx_open;
    assign host.tx_valid = (state_q == REPLY);
    assign host.tx_data  = tx_byte;
    assign busy          = (state_q != IDLE);
    assign frame_err     = in_frame && timeout_hit;

    // Reply byte mux: captured word goes out LSB first, zero outside REPLY
    always_comb begin
        tx_byte = 8'h00;
        if (state_q == REPLY) begin
            case (cnt_q)
                2'd0:    tx_byte = reply_q[7:0];
                2'd1:    tx_byte = reply_q[15:8];
                2'd2:    tx_byte = reply_q[23:16];
                default: tx_byte = reply_q[31:24];
            endcase
        end
    end

    // FSM state, byte counter and inter-byte idle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state logic; the byte counter is shared by DATA and REPLY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (rx_fire) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (rx_fire) begin
                    state_d = DATA;
                    cnt_d   = 2'd0;
                    idle_d  = '0;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    idle_d = '0;
                    if (cnt_q == 2'd3) begin
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ISSUE: begin
                state_d = (act_q == 4'd3) ? WAIT : IDLE;
            end
            WAIT: begin
                state_d = REPLY;
                cnt_d   = 2'd0;
            end
            REPLY: begin
                if (tx_fire) begin
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame assembly, one-cycle action issue and pull-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q      <= '0;
            mindex_q   <= '0;
            index_q    <= '0;
            din_lo_q   <= '0;
            reply_q    <= '0;
            pio_action <= '0;
            pio_mindex <= '0;
            pio_index  <= '0;
            pio_din    <= '0;
        end else begin
            pio_action <= '0;
            if ((state_q == IDLE) && rx_fire) begin
                act_q    <= host.rx_data[3:0];
                mindex_q <= host.rx_data[5:4];
            end
            if ((state_q == HDR) && rx_fire) begin
                index_q <= host.rx_data[4:0];
            end
            if ((state_q == DATA) && rx_fire) begin
                case (cnt_q)
                    2'd0: din_lo_q[7:0]   <= host.rx_data;
                    2'd1: din_lo_q[15:8]  <= host.rx_data;
                    2'd2: din_lo_q[23:16] <= host.rx_data;
                    default: begin
                        pio_action <= act_q;
                        pio_mindex <= mindex_q;
                        pio_index  <= index_q;
                        pio_din    <= {host.rx_data, din_lo_q};
                    end
                endcase
            end
            if (state_q == WAIT) begin
                reply_q <= pio_dout;
            end
        end
    end
endmodule
